// File: rtl/bus_source_arbiter_if.sv
// rtl/bus_source_arbiter_if.sv - request/grant bundle between bus sources and the arbiter
// Optional conflict_cnt signal is present only when BUS_CONFLICT_CNT_EN is defined.
interface bus_source_arbiter_if #(
    parameter int NUM_SRC = 32,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 8
);
    logic [NUM_SRC-1:0] req;
    logic               rr_mode;
    logic               lock;
    logic [SEL_W-1:0]   select;
    logic [NUM_SRC-1:0] grant;
    logic               bus_valid;
    logic               conflict;
`ifdef BUS_CONFLICT_CNT_EN
    logic [CNT_W-1:0]   conflict_cnt;
`else
    logic               unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

    // master: the arbiter itself; slave: the requesting sources
    modport master (
        input  req, rr_mode, lock,
        output select, grant, bus_valid, conflict
`ifdef BUS_CONFLICT_CNT_EN
        , output conflict_cnt
`endif
    );

    modport slave (
        output req, rr_mode, lock,
        input  select, grant, bus_valid, conflict
`ifdef BUS_CONFLICT_CNT_EN
        , input conflict_cnt
`endif
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// rtl/bus_source_arbiter.sv - fixed-priority / round-robin bus source arbiter with lock
// Define BUS_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module bus_source_arbiter #(
    parameter int NUM_SRC = 32,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    bus_source_arbiter_if.master  bus
);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

    logic [SEL_W-1:0]   select_q, select_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               bus_valid_q, bus_valid_d;
    logic               conflict_q, conflict_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               hold;
    logic               multi;
    logic [SEL_W-1:0]   win_idx;

    // First asserted bit strictly after p, wrapping; p = LAST_IDX gives plain lowest-index priority.
    function automatic logic [SEL_W-1:0] pick_after(input logic [NUM_SRC-1:0] r,
                                                    input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] ci;
        logic             found;
        int               c;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            c = int'(p) + k;
            if (c >= NUM_SRC) c = c - NUM_SRC;
            ci = SEL_W'(c);
            if (!found && r[ci]) begin
                idx   = ci;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    always_comb begin
        multi   = |(bus.req & (bus.req - 1'b1));
        hold    = bus.lock && bus_valid_q && bus.req[select_q];
        win_idx = pick_after(bus.req, bus.rr_mode ? ptr_q : LAST_IDX);

        select_d    = select_q;
        grant_d     = grant_q;
        bus_valid_d = bus_valid_q;
        ptr_d       = ptr_q;
        conflict_d  = multi;

        if (!hold) begin
            if (bus.req == '0) begin
                select_d    = '0;
                grant_d     = '0;
                bus_valid_d = 1'b0;
            end else begin
                select_d    = win_idx;
                grant_d     = NUM_SRC'(1) << win_idx;
                bus_valid_d = 1'b1;
                if (bus.rr_mode) ptr_d = win_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            select_q    <= '0;
            grant_q     <= '0;
            bus_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
            ptr_q       <= LAST_IDX;
        end else begin
            select_q    <= select_d;
            grant_q     <= grant_d;
            bus_valid_q <= bus_valid_d;
            conflict_q  <= conflict_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.select    = select_q;
    assign bus.grant     = grant_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.conflict  = conflict_q;

`ifdef BUS_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (multi && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.conflict_cnt = cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb/tb_bus_source_arbiter.sv - directed scoreboard bench for bus_source_arbiter
module tb_bus_source_arbiter;
`ifdef BUS_CONFLICT_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    typedef struct {
        string       tag;
        logic [4:0]  sel;
        logic        valid;
        logic        conf;
        int          cnt;
    } exp_t;

    exp_t sb[$];

    bus_source_arbiter_if #(.NUM_SRC(32), .SEL_W(5), .CNT_W(CW)) bif ();

    bus_source_arbiter #(.NUM_SRC(32), .SEL_W(5), .CNT_W(CW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".select"}, 32'(bif.select), 32'd0);
        chk({tag, ".grant"}, bif.grant, 32'd0);
        chk({tag, ".bus_valid"}, 32'(bif.bus_valid), 32'd0);
        chk({tag, ".conflict"}, 32'(bif.conflict), 32'd0);
`ifdef BUS_CONFLICT_CNT_EN
        chk({tag, ".conflict_cnt"}, 32'(bif.conflict_cnt), 32'd0);
`endif
    endtask

    // Drive one cycle of stimulus, queue what the arbiter must show after the next edge, then compare.
    task automatic step(input string tag, input logic [31:0] r, input logic rr, input logic lk,
                        input int esel, input logic ev, input logic ec);
        exp_t e;
        exp_t got;
        bif.req     = r;
        bif.rr_mode = rr;
        bif.lock    = lk;
        if (ec && exp_cnt < (1 << CW) - 1) exp_cnt++;
        e.tag = tag; e.sel = 5'(esel); e.valid = ev; e.conf = ec; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk({got.tag, ".select"}, 32'(bif.select), 32'(got.sel));
        chk({got.tag, ".grant"}, bif.grant, got.valid ? (32'd1 << got.sel) : 32'd0);
        chk({got.tag, ".bus_valid"}, 32'(bif.bus_valid), 32'(got.valid));
        chk({got.tag, ".conflict"}, 32'(bif.conflict), 32'(got.conf));
`ifdef BUS_CONFLICT_CNT_EN
        chk({got.tag, ".conflict_cnt"}, 32'(bif.conflict_cnt), 32'(got.cnt));
`endif
    endtask

    initial begin
        bif.req     = '0;
        bif.rr_mode = 1'b0;
        bif.lock    = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clock);
        clear = 1'b1;

        // fixed priority
        step("fp_0x30",     32'h0000_0030, 1'b0, 1'b0, 4,  1'b1, 1'b1);
        step("idle",        32'h0000_0000, 1'b0, 1'b0, 0,  1'b0, 1'b0);
        step("fp_multi",    32'hF0F0_0000, 1'b0, 1'b0, 20, 1'b1, 1'b1);
        step("fp_single",   32'h8000_0000, 1'b0, 1'b0, 31, 1'b1, 1'b0);

        // round robin from reset pointer (fixed mode left ptr at 31)
        step("rr7_a",       32'h0000_0007, 1'b1, 1'b0, 0,  1'b1, 1'b1);
        step("rr7_b",       32'h0000_0007, 1'b1, 1'b0, 1,  1'b1, 1'b1);
        step("rr7_c",       32'h0000_0007, 1'b1, 1'b0, 2,  1'b1, 1'b1);
        step("rr7_d",       32'h0000_0007, 1'b1, 1'b0, 0,  1'b1, 1'b1);

        // wrap-around
        step("rr_to31",     32'h8000_0000, 1'b1, 1'b0, 31, 1'b1, 1'b0);
        step("rr_wrap",     32'h8000_0001, 1'b1, 1'b0, 0,  1'b1, 1'b1);
        step("rr_only31",   32'h8000_0000, 1'b1, 1'b0, 31, 1'b1, 1'b0);

        // mode switch keeps ptr (31), so rr search after fixed grant restarts at 0
        step("fp_keepptr",  32'h8000_0001, 1'b0, 1'b0, 0,  1'b1, 1'b1);
        step("rr_afterfp",  32'h8000_0001, 1'b1, 1'b0, 0,  1'b1, 1'b1);

        // lock
        step("lk_g5",       32'h0000_0020, 1'b0, 1'b0, 5,  1'b1, 1'b0);
        step("lk_hold1",    32'h0000_0021, 1'b0, 1'b1, 5,  1'b1, 1'b1);
        step("lk_hold2",    32'h0000_0021, 1'b0, 1'b1, 5,  1'b1, 1'b1);
        step("lk_hold3",    32'h0000_0021, 1'b0, 1'b1, 5,  1'b1, 1'b1);
        step("lk_drop",     32'h0000_0001, 1'b0, 1'b1, 0,  1'b1, 1'b0);
        step("lk_idle",     32'h0000_0000, 1'b0, 1'b1, 0,  1'b0, 1'b0);
        step("lk_novalid",  32'h0000_0021, 1'b0, 1'b1, 0,  1'b1, 1'b1);

        // clear mid-lock (rr ptr is 0 from rr_afterfp)
        step("cl_g1",       32'h0000_00FF, 1'b1, 1'b0, 1,  1'b1, 1'b1);
        step("cl_hold",     32'h0000_00FF, 1'b1, 1'b1, 1,  1'b1, 1'b1);
        #3;
        clear = 1'b0;
        #1;
        exp_cnt = 0;
        check_zero("clear_async");
        #2;
        clear = 1'b1;
        step("cl_first",    32'h0000_00FF, 1'b1, 1'b1, 0,  1'b1, 1'b1);
        step("cl_end",      32'h0000_0000, 1'b0, 1'b0, 0,  1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bus_source_arbiter.md
BUS_SOURCE_ARBITER -- requirements
Module: bus_source_arbiter

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 32, number of bus-driving sources (2..32).
REQ-002 SHALL provide parameter SEL_W, default 5, select width, equal to ceil(log2(NUM_SRC)).
REQ-003 SHALL provide parameter CNT_W, default 8, conflict-counter width.
REQ-004 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-005 SHALL have port clear  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_SRC  per-source "drive bus" request; bit i is source i.
REQ-007 SHALL have port rr_mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-008 SHALL have port lock  input  1  hold the current grant while its request stays high.
REQ-009 SHALL have port select  output  SEL_W  registered bus-mux select, the index of the granted source.
REQ-010 SHALL have port grant  output  NUM_SRC  registered one-hot grant.
REQ-011 SHALL have port bus_valid  output  1  registered; 1 when some source is granted.
REQ-012 SHALL have port conflict  output  1  registered; 1 when the previous cycle had more than one request.
REQ-013 SHALL have port conflict_cnt  output  CNT_W  saturating count of conflict cycles; present only under the macro in REQ-030.

Function
REQ-014 SHALL register all outputs with 1-cycle latency: outputs after edge n reflect the inputs sampled at edge n.
REQ-015 SHALL, with rr_mode=0, grant the lowest-index asserted req bit.
REQ-016 SHALL, with rr_mode=1, grant the first asserted bit found searching upward from ptr+1, wrapping from NUM_SRC-1 to 0.
REQ-017 SHALL load ptr with the granted index on every grant while rr_mode=1, and leave ptr unchanged while rr_mode=0.
REQ-018 SHALL hold grant, select and ptr unchanged, ignoring all other requests, when lock=1, bus_valid=1 and req[select]=1 at the edge.
REQ-019 SHALL ignore lock when req[select]=0 or bus_valid=0, and arbitrate normally in that case.
REQ-020 SHALL drive select=0, grant=0 and bus_valid=0 on the next edge when req=0.
REQ-021 SHALL keep grant one-hot or zero at all times, with grant[select]=bus_valid.
REQ-022 SHALL apply an rr_mode change at the next edge without resetting ptr.
REQ-023 SHALL set conflict=1 after an edge at which popcount(req)>1, and 0 otherwise, independent of lock.
REQ-024 SHALL treat req bits at or above NUM_SRC as absent, and SHALL never produce select>=NUM_SRC.

Reset
REQ-025 SHALL, while clear=0, asynchronously force select=0, grant=0, bus_valid=0, conflict=0 and conflict_cnt=0.
REQ-026 SHALL reset ptr to NUM_SRC-1, so the first round-robin search starts at source 0.
REQ-027 SHALL, on clear asserted mid-grant or mid-lock, drop the grant immediately; the first edge after clear rises arbitrates with no lock history.

Configuration
REQ-028 SHALL contain no feature other than the one in REQ-030 selectable at compile time.
REQ-029 SHALL behave identically in all other respects whether or not the macro is defined.
REQ-030 SHALL, when BUS_CONFLICT_CNT_EN is defined, include conflict_cnt, incrementing once per cycle in which conflict is set and saturating at 2^CNT_W-1; without the macro, the port and counter SHALL be absent, and conflict SHALL still operate.

Verification
REQ-031 SHALL cover: rr_mode=0, req=0x0000_0030 for 1 cycle -> next cycle select=4, grant=0x10, bus_valid=1, conflict=1.
REQ-032 SHALL cover: rr_mode=1, req=0x0000_0007 held 4 cycles after reset -> select sequence 0,1,2,0.
REQ-033 SHALL cover: rr_mode=1, ptr=31, req=0x8000_0001 -> select=0 (wrap-around); then with only bit 31 set -> select=31.
REQ-034 SHALL cover: grant on 5, then lock=1 and req=0x21 for 3 cycles -> select stays 5; req[5] drops -> next cycle select=0.
REQ-035 SHALL cover: clear pulsed low mid-lock with req=0xFF -> outputs 0 asynchronously; first edge after release with rr_mode=1 -> select=0.
REQ-036 SHALL cover, with BUS_CONFLICT_CNT_EN and CNT_W=2: 5 conflict cycles -> conflict_cnt=3 (saturated); without the macro, the build SHALL have no conflict_cnt port.
